// File: rtl/mux_rr_arbiter_if.sv
// Bus between four requesters and the round-robin arbiter that shares one 4:1 single-bit mux.
// Requesters drive req/d_in; the arbiter returns grant, mux selects, gated data and debug state.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] d_in;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;
  logic       data_out;
  logic       out_valid;
  logic       dbg_state;

  // Handshake: out_valid high qualifies data_out in the same cycle; there is no
  // backpressure. A requester owns the channel exactly while its gnt bit is set.
  modport master (
    output req, d_in,
    input  gnt, s1, s0, busy, data_out, out_valid, dbg_state
  );

  modport slave (
    input  req, d_in,
    output gnt, s1, s0, busy, data_out, out_valid, dbg_state
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the selects of a 4:1 single-bit mux.
// Each grant is capped at HOLD_MAX cycles; releases hand over directly when another requester waits.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mux_rr_arbiter_if.slave  bus
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_ptr,   w_ptr_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;

  logic          w_busy;
  logic [2:0]    w_pick_idle;
  logic [2:0]    w_pick_rel;
  logic [3:0]    w_req_masked;
  logic [1:0]    w_owner_inc;

  // Returns {found, index}: first set bit scanning p, p+1, .. mod 4.
  // The loop runs from the farthest offset down so the nearest hit is written last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_owner_inc  = r_owner + 2'd1;
  assign w_req_masked = bus.req & ~(4'b0001 << r_owner);
  assign w_pick_idle  = rr_pick(bus.req, r_ptr);
  assign w_pick_rel   = rr_pick(w_req_masked, w_owner_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_pick_idle[1:0];
          w_cnt_nxt   = CW'(1);
        end
      end
      GRANT: begin
        if (bus.req[r_owner] && (r_cnt < CW'(HOLD_MAX))) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          // Release: rotation restarts after the old owner, which is masked out.
          w_ptr_nxt = w_owner_inc;
          if (w_pick_rel[2]) begin
            w_owner_nxt = w_pick_rel[1:0];
            w_cnt_nxt   = CW'(1);
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_busy        = (r_state == GRANT);
  assign bus.gnt       = w_busy ? (4'b0001 << r_owner) : 4'b0000;
  assign bus.s1        = w_busy & r_owner[1];
  assign bus.s0        = w_busy & r_owner[0];
  assign bus.busy      = w_busy;
  assign bus.out_valid = w_busy;
  assign bus.data_out  = w_busy & bus.d_in[r_owner];
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (HOLD_MAX=4): reset, capping, rotation, early release,
// data gating and reset during a grant, with hand-computed expectations.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic chk_grant(input string tag, input logic [3:0] eg);
    chk({tag, ".gnt"},   bus.gnt, eg);
    chk({tag, ".s"},     {2'b00, bus.s1, bus.s0}, {2'b00, idx_of(eg)});
    chk({tag, ".busy"},  {3'b000, bus.busy}, {3'b000, |eg});
    chk({tag, ".valid"}, {3'b000, bus.out_valid}, {3'b000, |eg});
    chk({tag, ".state"}, {3'b000, bus.dbg_state}, {3'b000, |eg});
  endtask

  initial begin
    logic [3:0] eg;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = 4'b1111;
    bus.d_in = 4'b0000;

    // 1: reset holds everything idle despite full request load
    for (int c = 0; c < 3; c++) begin
      tick;
      chk_grant($sformatf("t1.rst%0d", c), 4'b0000);
    end
    rst = 1'b0;
    tick;
    chk_grant("t1.first", 4'b0001);

    // 3: full load rotates 0,1,2,3,0 with 4 cycles each and no gaps
    for (int c = 1; c < 20; c++) begin
      tick;
      eg = 4'b0001 << ((c / 4) % 4);
      chk_grant($sformatf("t3.c%0d", c), eg);
    end

    // 2 + 5: lone requester 2 is capped at 4 cycles, then one idle cycle
    rst     = 1'b1;
    bus.req = 4'b0100;
    tick;
    chk_grant("t2.rst", 4'b0000);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      eg = ((c % 5) < 4) ? 4'b0100 : 4'b0000;
      chk_grant($sformatf("t2.c%0d", c), eg);
      if (c == 0) begin
        bus.d_in = 4'b0100;
        #1;
        chk("t5.sel_one", {3'b000, bus.data_out}, 4'b0001);
        bus.d_in = 4'b1011;
        #1;
        chk("t5.sel_zero", {3'b000, bus.data_out}, 4'b0000);
      end
      if (c == 4) begin
        bus.d_in = 4'b1111;
        #1;
        chk("t5.idle_gate", {3'b000, bus.data_out}, 4'b0000);
      end
    end
    bus.d_in = 4'b0000;

    // 4: owner 1 drops after 2 cycles with req3 pending -> direct handover, cnt restarts.
    // The reset must return ptr to 0, otherwise ptr=3 from t2 would pick requester 3 first.
    rst     = 1'b1;
    bus.req = 4'b1010;
    tick;
    chk_grant("t4.rst", 4'b0000);
    rst = 1'b0;
    tick;
    chk_grant("t4.own1_c1", 4'b0010);
    tick;
    chk_grant("t4.own1_c2", 4'b0010);
    bus.req = 4'b1000;
    tick;
    chk_grant("t4.hand3", 4'b1000);
    for (int c = 2; c <= 4; c++) begin
      tick;
      chk_grant($sformatf("t4.own3_c%0d", c), 4'b1000);
    end
    tick;
    chk_grant("t4.cap_idle", 4'b0000);

    // 6: reset at cycle 2 of a grant drops it at that edge; ptr returns to 0
    tick;
    chk_grant("t6.c1", 4'b1000);
    tick;
    chk_grant("t6.c2", 4'b1000);
    rst     = 1'b1;
    bus.req = 4'b1111;
    tick;
    chk_grant("t6.rst", 4'b0000);
    rst = 1'b0;
    tick;
    chk_grant("t6.after", 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
